oka_mul_arbiter: RTL and testbench



---
 rtl/oka_mul_arbiter_if.sv | 25 ++
 rtl/oka_mul_arbiter.sv | 129 ++++++++++++
 tb/tb_oka_mul_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/oka_mul_arbiter_if.sv
// Request/response channel bundle between the requesting units and the shared multiplier arbiter.
interface oka_mul_arbiter_if #(
   parameter int NREQ = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*8-1:0] req_a;
   logic [NREQ*8-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [7:0]        rsp_y;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_y
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_y
   );
endinterface

// File: rtl/oka_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 8-bit multiplier core,
// holding operands MUL_LAT cycles (multicycle path) before sampling the result.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | searching for a request from ptr upward, core inputs held
// S_WAIT | operands stable on the core, counting down MUL_LAT cycles
// S_RESP | result presented on rsp channel until rsp_ready
module oka_mul_arbiter #(
   parameter int NREQ    = 4,
   parameter int MUL_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   oka_mul_arbiter_if.slave    bus,
   output logic [7:0]          mul_a,
   output logic [7:0]          mul_b,
   input  logic [7:0]          mul_y,
   output logic                busy
);
   localparam int IDW = $clog2(NREQ);
   localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

   generate
      if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
         $error("oka_mul_arbiter: NREQ must be 2..8");
      end
      if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_lat
         $error("oka_mul_arbiter: MUL_LAT must be 1..15");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          state_q;
   logic [IDW-1:0]  ptr_q;
   logic [IDW-1:0]  id_q;
   logic [3:0]      cnt_q;
   logic [7:0]      mul_a_q;
   logic [7:0]      mul_b_q;
   logic            rsp_valid_q;
   logic [IDW-1:0]  rsp_id_q;
   logic [7:0]      rsp_y_q;

   logic            grant_vld;
   logic [IDW-1:0]  grant_idx;
   logic [NREQ-1:0] grant_oh;

   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return IDW'(s);
   endfunction

   // Scan from the farthest offset down so the requester closest to ptr wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (bus.req_valid[wrap_add(ptr_q, j)]) begin
            grant_vld = 1'b1;
            grant_idx = wrap_add(ptr_q, j);
         end
      end
   end

   // rst_n gates the accept so requesters never see ready while reset is held.
   always_comb begin
      grant_oh = '0;
      if (grant_vld && state_q == S_IDLE && rst_n) grant_oh[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         cnt_q       <= '0;
         mul_a_q     <= 8'h00;
         mul_b_q     <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_y_q     <= 8'h00;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (grant_vld) begin
                  mul_a_q <= bus.req_a[grant_idx*8 +: 8];
                  mul_b_q <= bus.req_b[grant_idx*8 +: 8];
                  id_q    <= grant_idx;
                  ptr_q   <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                  cnt_q   <= CNT_LOAD;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  rsp_y_q     <= mul_y;
                  rsp_id_q    <= id_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = grant_oh;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_y     = rsp_y_q;
   assign mul_a         = mul_a_q;
   assign mul_b         = mul_b_q;
   assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_oka_mul_arbiter.sv
// Directed bench for oka_mul_arbiter: a MUL_LAT=1 instance with a response scoreboard
// and a MUL_LAT=3 instance whose core stub returns garbage until the result is due.
module tb_oka_mul_arbiter;
   localparam int NREQ = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   oka_mul_arbiter_if #(.NREQ(NREQ)) bus0 ();
   oka_mul_arbiter_if #(.NREQ(NREQ)) bus1 ();

   logic [7:0] mul_a0, mul_b0, mul_y0;
   logic [7:0] mul_a1, mul_b1, mul_y1, prod1;
   logic       busy0, busy1;
   logic [7:0] opa0 [NREQ];
   logic [7:0] opb0 [NREQ];
   logic [7:0] opa1 [NREQ];
   logic [7:0] opb1 [NREQ];
   logic [3:0] hold1 = 4'd15;

   assign bus0.req_a = {opa0[3], opa0[2], opa0[1], opa0[0]};
   assign bus0.req_b = {opb0[3], opb0[2], opb0[1], opb0[0]};
   assign bus1.req_a = {opa1[3], opa1[2], opa1[1], opa1[0]};
   assign bus1.req_b = {opb1[3], opb1[2], opb1[1], opb1[0]};

   assign mul_y0 = 8'(mul_a0 * mul_b0);

   // Slow core stub: output is valid only in the cycle ending at accept+3.
   always @(posedge clk) begin
      if (|(bus1.req_valid & bus1.req_ready)) hold1 <= 4'd0;
      else if (hold1 != 4'd15)                hold1 <= hold1 + 4'd1;
   end
   assign prod1  = 8'(mul_a1 * mul_b1);
   assign mul_y1 = (hold1 >= 4'd2) ? prod1 : 8'hAA;

   oka_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0),
      .mul_a(mul_a0), .mul_b(mul_b0), .mul_y(mul_y0), .busy(busy0)
   );

   oka_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1),
      .mul_a(mul_a1), .mul_b(mul_b1), .mul_y(mul_y1), .busy(busy1)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int hs_cyc   = 0;
   logic saw_rsp = 1'b0;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] y;
   } exp_t;

   exp_t sb0 [$];
   int   grant_id  [$];
   int   grant_cyc [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock of dut0: log accepts into the scoreboard, check responses on handshake.
   task automatic tick();
      logic [NREQ-1:0] hs;
      exp_t e;
      #1;
      hs = bus0.req_valid & bus0.req_ready;
      for (int i = 0; i < NREQ; i++) begin
         if (hs[i]) begin
            sb0.push_back({2'(i), 8'(opa0[i] * opb0[i])});
            grant_id.push_back(i);
            grant_cyc.push_back(cyc);
         end
      end
      if (bus0.rsp_valid) saw_rsp = 1'b1;
      if (bus0.rsp_valid && bus0.rsp_ready) begin
         chk("rsp_expected", 32'(sb0.size() != 0), 32'd1);
         if (sb0.size() != 0) begin
            e = sb0.pop_front();
            chk("rsp_id", 32'(bus0.rsp_id), 32'(e.id));
            chk("rsp_y", 32'(bus0.rsp_y), 32'(e.y));
         end
      end
      @(negedge clk);
      cyc++;
      #1;
   endtask

   task automatic drain(input string tag);
      for (int n = 0; n < 20 && sb0.size() != 0; n++) tick();
      chk(tag, 32'(sb0.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n          = 1'b0;
      bus0.req_valid = '1;
      bus1.req_valid = '1;
      bus0.rsp_ready = 1'b0;
      bus1.rsp_ready = 1'b0;
      opa0 = '{8'h10, 8'h07, 8'h03, 8'hFF};
      opb0 = '{8'h11, 8'h09, 8'h05, 8'h02};
      opa1 = '{8'hFF, 8'h00, 8'h00, 8'h00};
      opb1 = '{8'hFF, 8'h00, 8'h00, 8'h00};

      // Reset with all requests asserted
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_ready0", 32'(bus0.req_ready), 32'd0);
      chk("rst_req_ready1", 32'(bus1.req_ready), 32'd0);
      chk("rst_mul_a", 32'(mul_a0), 32'd0);
      chk("rst_mul_b", 32'(mul_b0), 32'd0);
      chk("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
      chk("rst_rsp_y", 32'(bus0.rsp_y), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      bus1.req_valid = '0;
      rst_n = 1'b1;
      #1;
      chk("first_grant", 32'(bus0.req_ready), 32'h1);

      // Fairness: all requesting, consumer always ready
      bus0.rsp_ready = 1'b1;
      for (int n = 0; n < 40 && grant_id.size() < 5; n++) tick();
      bus0.req_valid = '0;
      chk("fair_count", 32'(grant_id.size()), 32'd5);
      for (int i = 0; i < 5 && i < grant_id.size(); i++) begin
         chk("fair_order", 32'(grant_id[i]), 32'(i % NREQ));
         if (i > 0) chk("fair_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd3);
      end
      drain("fair_drain");

      // Single request from requester 2 (ptr is now 1)
      bus0.req_valid = 4'b0100;
      #1;
      chk("single_req_ready", 32'(bus0.req_ready), 32'b0100);
      tick();
      bus0.req_valid = '0;
      chk("single_mul_a", 32'(mul_a0), 32'h03);
      chk("single_mul_b", 32'(mul_b0), 32'h05);
      chk("single_not_yet", 32'(bus0.rsp_valid), 32'd0);
      tick();
      chk("single_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
      chk("single_rsp_id", 32'(bus0.rsp_id), 32'd2);
      chk("single_rsp_y", 32'(bus0.rsp_y), 32'h0F);
      drain("single_drain");

      // Backpressure: ptr is 3, requesters 0 and 3 pending
      bus0.rsp_ready = 1'b0;
      bus0.req_valid = 4'b1001;
      tick();
      chk("bp_grant", 32'(grant_id[$]), 32'd3);
      tick();
      for (int n = 0; n < 5; n++) begin
         chk("bp_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
         chk("bp_rsp_y", 32'(bus0.rsp_y), 32'hFE);
         chk("bp_rsp_id", 32'(bus0.rsp_id), 32'd3);
         chk("bp_mul_a", 32'(mul_a0), 32'hFF);
         chk("bp_mul_b", 32'(mul_b0), 32'h02);
         chk("bp_req_ready", 32'(bus0.req_ready), 32'd0);
         chk("bp_busy", 32'(busy0), 32'd1);
         tick();
      end
      bus0.rsp_ready = 1'b1;
      hs_cyc = cyc;
      tick();
      tick();
      bus0.req_valid = '0;
      chk("bp_next_grant", 32'(grant_id[$]), 32'd0);
      chk("bp_next_cycle", 32'(grant_cyc[$] - hs_cyc), 32'd1);
      drain("bp_drain");

      // Idle: core inputs must hold the last operands
      repeat (3) tick();
      chk("idle_mul_a", 32'(mul_a0), 32'h10);
      chk("idle_mul_b", 32'(mul_b0), 32'h11);
      chk("idle_busy", 32'(busy0), 32'd0);

      // MUL_LAT=3 instance, slow core stub
      bus1.req_valid = 4'b0001;
      #1;
      chk("lat3_req_ready", 32'(bus1.req_ready), 32'b0001);
      @(negedge clk);
      #1;
      bus1.req_valid = '0;
      chk("lat3_mul_a", 32'(mul_a1), 32'hFF);
      for (int j = 0; j < 5; j++) begin
         chk("lat3_rsp_valid", 32'(bus1.rsp_valid), 32'(j >= 3));
         if (j == 3) begin
            chk("lat3_rsp_y", 32'(bus1.rsp_y), 32'h01);
            chk("lat3_rsp_id", 32'(bus1.rsp_id), 32'd0);
         end
         @(negedge clk);
         #1;
      end
      bus1.rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("lat3_idle", 32'(busy1), 32'd0);

      // Reset pulse while dut0 is in WAIT
      bus0.rsp_ready = 1'b1;
      bus0.req_valid = 4'b0100;
      tick();
      bus0.req_valid = '0;
      chk("mid_busy", 32'(busy0), 32'd1);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_mul_a", 32'(mul_a0), 32'd0);
      chk("mid_rst_busy", 32'(busy0), 32'd0);
      rst_n = 1'b1;
      sb0.delete();
      saw_rsp = 1'b0;
      repeat (5) tick();
      chk("mid_no_rsp", 32'(saw_rsp), 32'd0);
      bus0.req_valid = 4'b1010;
      #1;
      chk("mid_ptr_grant", 32'(bus0.req_ready), 32'b0010);
      tick();
      bus0.req_valid = '0;
      drain("mid_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
